// File: rtl/deflation_sched_pkg.sv
// Shared types for the deflation scheduler: FSM states, component index width
// and the double-precision word type used by the surrounding datapath.
package deflation_sched_pkg;

  localparam int COMP_IDX_W = 4;

  typedef logic [COMP_IDX_W-1:0] comp_idx_t;
  typedef logic [63:0]           fp_double;

  typedef enum logic [2:0] {
    IDLE,
    PI_GO,
    PI_WAIT,
    STORE,
    UPD_HOLD,
    UPD_WAIT,
    COMMIT,
    FINISH
  } sched_state_t;

  // A zero or over-range request falls back to the build-time maximum.
  function automatic comp_idx_t clamp_count(input comp_idx_t req, input comp_idx_t max_c);
    return (req == '0 || req > max_c) ? max_c : req;
  endfunction

endpackage

// File: rtl/deflation_timer.sv
// Loadable down-counter that saturates at zero; shared by the power-iteration
// timeout and the deflation hold interval.
module deflation_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/deflation_sched.sv
// Sequences power iteration, eigenvector store and covariance deflation for
// up to NUM_COMP eigencomponents; every output is a flop.
module deflation_sched
  import deflation_sched_pkg::*;
#(
  parameter int NUM_COMP   = 4,
  parameter int UPD_LAT    = 6,
  parameter int PI_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] num_comp,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] comp_idx,
  output logic       pi_start,
  input  logic       pi_valid,
  output logic       eig_we,
  output logic [3:0] eig_addr,
  output logic       cov_sel,
  output logic       upd_start,
  input  logic       upd_valid,
  output logic       cov_we
);

  localparam int TMR_MAX = (PI_TIMEOUT > UPD_LAT) ? PI_TIMEOUT : UPD_LAT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] PI_LOAD   = TMR_W'(PI_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(UPD_LAT - 1);
  localparam comp_idx_t        MAX_COMP  = comp_idx_t'(NUM_COMP);

  sched_state_t     state;
  comp_idx_t        n_eff;
  logic             tmr_load;
  logic             tmr_dec;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_zero;

  // Timer is reloaded on the way into each wait and counts down only inside it.
  always_comb begin
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = '0;
    case (state)
      PI_GO: begin
        tmr_load = 1'b1;
        tmr_val  = PI_LOAD;
      end
      STORE: begin
        tmr_load = 1'b1;
        tmr_val  = HOLD_LOAD;
      end
      PI_WAIT, UPD_HOLD: tmr_dec = 1'b1;
      default: ;
    endcase
  end

  deflation_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      n_eff     <= '0;
      comp_idx  <= '0;
      cov_sel   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      pi_start  <= 1'b0;
      eig_we    <= 1'b0;
      upd_start <= 1'b0;
      cov_we    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_eff    <= clamp_count(num_comp, MAX_COMP);
            comp_idx <= '0;
            cov_sel  <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b1;
            pi_start <= 1'b1;
            state    <= PI_GO;
          end
        end
        PI_GO: begin
          pi_start <= 1'b0;
          state    <= PI_WAIT;
        end
        PI_WAIT: begin
          // A result arriving on the final timeout cycle still counts.
          if (pi_valid) begin
            eig_we <= 1'b1;
            state  <= STORE;
          end else if (tmr_zero) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= FINISH;
          end
        end
        STORE: begin
          eig_we <= 1'b0;
          if (comp_idx == n_eff - 1'b1) begin
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            upd_start <= 1'b1;
            state     <= UPD_HOLD;
          end
        end
        UPD_HOLD: begin
          if (tmr_zero) begin
            state <= UPD_WAIT;
          end
        end
        UPD_WAIT: begin
          if (upd_valid) begin
            upd_start <= 1'b0;
            cov_we    <= 1'b1;
            state     <= COMMIT;
          end
        end
        COMMIT: begin
          cov_we   <= 1'b0;
          cov_sel  <= 1'b1;
          comp_idx <= comp_idx + 1'b1;
          pi_start <= 1'b1;
          state    <= PI_GO;
        end
        FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign eig_addr = comp_idx;

  a_idx_in_range: assert property (@(posedge clk) disable iff (!rst)
    busy |-> (comp_idx < n_eff));

  a_strobes_exclusive: assert property (@(posedge clk) disable iff (!rst)
    $onehot0({pi_start, eig_we, cov_we, done}));

endmodule

// File: doc/deflation_sched.md
DEFLATION_SCHED -- requirements
Module: deflation_sched

Interface
REQ-001 Parameter NUM_COMP, default 4: maximum eigencomponents extracted per run, range 1..15.
REQ-002 Parameter UPD_LAT, default 6: cycles upd_start is held high before upd_valid is accepted; covers the multiply/subtract pipeline of the deflation datapath.
REQ-003 Parameter PI_TIMEOUT, default 4096: maximum cycles to wait for pi_valid.
REQ-004 clk  in  1  sole clock, all flops rising-edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  run request, sampled only in IDLE.
REQ-007 num_comp  in  4  requested component count, sampled with start.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle pulse at run completion.
REQ-010 err  out  1  sticky timeout flag, cleared by the next accepted start.
REQ-011 comp_idx  out  4  current component index, drives count_n of the deflation datapath.
REQ-012 pi_start  out  1  one-cycle pulse launching the power-iteration engine.
REQ-013 pi_valid  in  1  eigenvector/eigenvalue ready from the power-iteration engine.
REQ-014 eig_we  out  1  one-cycle write strobe into the eigenvector store.
REQ-015 eig_addr  out  4  eigenvector store address, equal to comp_idx.
REQ-016 cov_sel  out  1  0 = initial covariance feeds the datapath, 1 = deflated covariance register.
REQ-017 upd_start  out  1  level start to the deflation datapath.
REQ-018 upd_valid  in  1  deflated matrix valid from the datapath.
REQ-019 cov_we  out  1  one-cycle load strobe of the deflated covariance register.

Function
REQ-020 States: IDLE, PI_GO, PI_WAIT, STORE, UPD_HOLD, UPD_WAIT, COMMIT, FINISH.
REQ-021 IDLE: on start=1, latch n_eff = (num_comp==0 or num_comp>NUM_COMP) ? NUM_COMP : num_comp, set comp_idx=0 and cov_sel=0, clear err, go to PI_GO.
REQ-022 PI_GO: assert pi_start for exactly one cycle, clear the timeout counter, go to PI_WAIT.
REQ-023 PI_WAIT: on pi_valid go to STORE; otherwise increment the timeout counter; on reaching PI_TIMEOUT-1 set err and go to FINISH.
REQ-024 STORE: eig_we=1 for one cycle with eig_addr=comp_idx; if comp_idx==n_eff-1 go to FINISH (last component, no deflation), else go to UPD_HOLD.
REQ-025 UPD_HOLD: upd_start=1; hold counter runs 0..UPD_LAT-1; upd_valid is ignored while the counter is below UPD_LAT-1; at UPD_LAT-1 go to UPD_WAIT.
REQ-026 UPD_WAIT: upd_start stays 1; on upd_valid go to COMMIT; no timeout applies.
REQ-027 COMMIT: cov_we=1 and upd_start=0 for one cycle, set cov_sel=1, increment comp_idx, go to PI_GO.
REQ-028 FINISH: done=1 for one cycle, go to IDLE; comp_idx retains its last value until the next start.
REQ-029 Whole-run latency for n_eff=1 with pi_valid k cycles after pi_start: done asserts k+3 cycles after start is sampled.
REQ-030 start while busy is ignored (no queueing); pi_valid or upd_valid outside their wait states is ignored.
REQ-031 pi_valid in the same cycle as the timeout limit is reached: valid wins, err stays 0.
REQ-032 All outputs are registered; comp_idx never exceeds n_eff-1.

Reset
REQ-033 rst=0 asynchronously forces IDLE, comp_idx=0, cov_sel=0, and all strobes, busy, done, err and upd_start to 0; timeout and hold counters clear.
REQ-034 Reset asserted mid-run aborts the run with no done pulse; the first start after release begins a full new run.

Structure
REQ-035 State enum and component-index width typedef live in the shared package alongside fp_double; no matrix data passes through this block.
REQ-036 The single sub-module is deflation_timer, a loadable down-counter shared by the timeout and UPD_LAT hold functions.

Verification
REQ-037 num_comp=3, pi_valid 10 cycles after each pi_start, upd_valid 8 cycles after upd_start rises -> 3 eig_we (addr 0,1,2), 2 cov_we, cov_sel 0→1 after the first COMMIT, single done, err=0.
REQ-038 num_comp=0 and num_comp=9 with NUM_COMP=4 -> 4 eig_we each run.
REQ-039 pi_valid never asserted -> err=1 and done exactly PI_TIMEOUT+2 cycles after start; a second start clears err.
REQ-040 upd_valid held high from the first cycle of UPD_HOLD -> COMMIT no earlier than UPD_LAT+1 cycles after upd_start rises.
REQ-041 rst pulsed low during UPD_WAIT -> all outputs 0 within the same cycle, no done pulse; the next run completes normally.
REQ-042 start pulsed during PI_WAIT -> no effect; eig_we count unchanged.
